dcp_tx_formatter: RTL and testbench

- Response end of the debug command processor print handshake (req_tx / type_tx / dout / ack_tx).
- Accepts one print request at a time: a raw byte, a 32-bit word as ASCII hex, or a word plus line break.
- Serialises the request into bytes for the UART byte transmitter over a valid/ready handshake.
- Raises ack_tx when the last byte has been accepted.

---
 rtl/dcp_tx_formatter.sv | 128 ++++++++++++
 tb/tb_dcp_tx_formatter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dcp_tx_formatter.sv
// Print formatter: serialises a raw byte, 8 hex digits and/or a line break to a byte stream.
// Latency: first tx_valid 2 cycles after req_tx accepted, then up to one byte per cycle.
// Backpressure: tx_valid/tx_data hold while tx_ready is low. DCP_TX_SEP_EN adds a space after hex digits.
module dcp_tx_formatter #(
  parameter bit HEX_LOWER = 1'b0,
  parameter bit NL_CR     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_tx,
  input  logic [1:0]  type_tx,
  input  logic [31:0] din,
  output logic        ack_tx,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, ACK} state_t;

`ifdef DCP_TX_SEP_EN
  localparam logic [3:0] DIGITS = 4'd9;
`else
  localparam logic [3:0] DIGITS = 4'd8;
`endif
  localparam logic [3:0] LB = NL_CR ? 4'd2 : 4'd1;

  state_t      state, state_d;
  logic [1:0]  type_q, type_d;
  logic [31:0] din_q, din_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic        tx_valid_d;
  logic [7:0]  tx_data_d;

  // Offset 10 folded into the base so n-10+'A' becomes n+base.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (HEX_LOWER ? 8'h57 : 8'h37) + {4'h0, n};
  endfunction

  function automatic logic [7:0] byte_at(input logic [1:0] t, input logic [31:0] d,
                                         input logic [3:0] i);
    logic [31:0] sh;
    logic [3:0]  k;
    sh = d << {i[2:0], 2'b00};
    k  = (t == 2'd3) ? i : i - DIGITS;
    if (t == 2'd0) return d[7:0];
    if (t != 2'd3 && i < 4'd8) return hex_char(sh[31:28]);
`ifdef DCP_TX_SEP_EN
    if (t != 2'd3 && i == 4'd8) return 8'h20;
`endif
    if (NL_CR && k == 4'd0) return 8'h0D;
    return 8'h0A;
  endfunction

  always_comb begin
    state_d    = state;
    type_d     = type_q;
    din_d      = din_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    tx_valid_d = tx_valid;
    tx_data_d  = tx_data;
    case (state)
      IDLE: begin
        if (req_tx) begin
          din_d   = din;
          type_d  = type_tx;
          idx_d   = 4'd0;
          state_d = LOAD;
          case (type_tx)
            2'd0:    cnt_d = 4'd1;
            2'd1:    cnt_d = DIGITS;
            2'd2:    cnt_d = DIGITS + LB;
            default: cnt_d = LB;
          endcase
        end
      end
      LOAD: begin
        tx_data_d  = byte_at(type_q, din_q, idx_q);
        tx_valid_d = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        if (tx_valid && tx_ready) begin
          if (idx_q + 4'd1 < cnt_q) begin
            idx_d     = idx_q + 4'd1;
            tx_data_d = byte_at(type_q, din_q, idx_q + 4'd1);
          end else begin
            tx_valid_d = 1'b0;
            state_d    = ACK;
          end
        end
      end
      ACK: begin
        // Requester must drop req_tx before another print can start.
        if (!req_tx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      type_q   <= 2'd0;
      din_q    <= 32'h0;
      cnt_q    <= 4'd0;
      idx_q    <= 4'd0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_d;
      type_q   <= type_d;
      din_q    <= din_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      tx_valid <= tx_valid_d;
      tx_data  <= tx_data_d;
    end
  end

  assign ack_tx = (state == ACK);
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_dcp_tx_formatter.sv
// Directed bench for dcp_tx_formatter; three instances cover the HEX_LOWER / NL_CR combinations.
module tb_dcp_tx_formatter;

`ifdef DCP_TX_SEP_EN
  localparam bit SEP = 1'b1;
`else
  localparam bit SEP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  type_tx;
  logic [31:0] din;
  logic        tx_ready;
  logic [2:0]  req, ack, vld, busy;
  logic [7:0]  dat [3];

  always #5 clk = ~clk;

  dcp_tx_formatter #(.HEX_LOWER(1'b0), .NL_CR(1'b1)) u0 (
    .clk(clk), .rst(rst), .req_tx(req[0]), .type_tx(type_tx), .din(din), .ack_tx(ack[0]),
    .tx_valid(vld[0]), .tx_data(dat[0]), .tx_ready(tx_ready), .busy(busy[0]));
  dcp_tx_formatter #(.HEX_LOWER(1'b1), .NL_CR(1'b1)) u1 (
    .clk(clk), .rst(rst), .req_tx(req[1]), .type_tx(type_tx), .din(din), .ack_tx(ack[1]),
    .tx_valid(vld[1]), .tx_data(dat[1]), .tx_ready(tx_ready), .busy(busy[1]));
  dcp_tx_formatter #(.HEX_LOWER(1'b0), .NL_CR(1'b0)) u2 (
    .clk(clk), .rst(rst), .req_tx(req[2]), .type_tx(type_tx), .din(din), .ack_tx(ack[2]),
    .tx_valid(vld[2]), .tx_data(dat[2]), .tx_ready(tx_ready), .busy(busy[2]));

  logic [1:0] sel;
  logic       s_vld, s_ack, s_busy;
  logic [7:0] s_dat;
  always_comb begin
    s_vld  = vld[sel];
    s_ack  = ack[sel];
    s_busy = busy[sel];
    s_dat  = dat[sel];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_cyc, last_cyc, ack_cyc;
  logic [7:0] got[$];
  logic [7:0] exp_b[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Raise the request and check the 2-cycle latency to tx_valid.
  task automatic start(input logic [1:0] s, input logic [1:0] t, input logic [31:0] d);
    sel = s; type_tx = t; din = d; req[s] = 1'b1;
    step();
    check("lat0_vld", {31'h0, s_vld}, 32'h0);
    check("lat0_busy", {31'h0, s_busy}, 32'h1);
    step();
    check("lat1_vld", {31'h0, s_vld}, 32'h1);
  endtask

  // mode 0: tx_ready held high; mode 1: tx_ready alternates 1/0. stop_at>0 returns after that many bytes.
  task automatic collect(input int mode, input int stop_at);
    logic       stall;
    logic [7:0] pd;
    got.delete();
    first_cyc = -1; last_cyc = -1; ack_cyc = -1;
    stall = 1'b0; pd = 8'h00;
    for (int k = 0; k < 200; k++) begin
      if (stall) begin
        check("stall_vld", {31'h0, s_vld}, 32'h1);
        check("stall_dat", {24'h0, s_dat}, {24'h0, pd});
      end
      if (s_ack) begin
        ack_cyc = cyc;
        break;
      end
      if (s_vld && first_cyc < 0) first_cyc = cyc;
      tx_ready = (mode == 0) ? 1'b1 : (k % 2 == 0);
      stall = s_vld && !tx_ready;
      pd = s_dat;
      if (s_vld && tx_ready) begin
        got.push_back(s_dat);
        last_cyc = cyc;
      end
      step();
      if (stop_at > 0 && got.size() == stop_at) return;
    end
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_count"}, got.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < got.size(); i++)
      check($sformatf("%s_b%0d", tag, i), {24'h0, got[i]}, {24'h0, exp_b[i]});
  endtask

  task automatic finish_ack(input string tag);
    check({tag, "_ack_rise"}, ack_cyc, last_cyc + 1);
    req[sel] = 1'b0;
    step();
    check({tag, "_ack_fall"}, {31'h0, s_ack}, 32'h0);
    check({tag, "_idle"}, {31'h0, s_busy}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; req = 3'b000; type_tx = 2'd0; din = 32'h0; tx_ready = 1'b1; sel = 2'd0;
    step(); step();
    for (int i = 0; i < 3; i++) begin
      check("rst_vld", {31'h0, vld[i]}, 32'h0);
      check("rst_dat", {24'h0, dat[i]}, 32'h0);
      check("rst_ack", {31'h0, ack[i]}, 32'h0);
      check("rst_busy", {31'h0, busy[i]}, 32'h0);
    end
    rst = 1'b0;
    step();

    // Raw byte.
    start(2'd0, 2'd0, 32'h00000050);
    collect(0, 0);
    exp_b = '{8'h50};
    check_bytes("t0");
    finish_ack("t0");

    // Uppercase hex, back-to-back.
    start(2'd0, 2'd1, 32'h1234ABCD);
    collect(0, 0);
    exp_b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44};
    if (SEP) exp_b.push_back(8'h20);
    check_bytes("t1");
    check("t1_consecutive", last_cyc - first_cyc, exp_b.size() - 1);
    finish_ack("t1");

    // Lowercase hex + CR LF with tx_ready toggling.
    start(2'd1, 2'd2, 32'h0000000F);
    collect(1, 0);
    exp_b = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h66};
    if (SEP) exp_b.push_back(8'h20);
    exp_b.push_back(8'h0D);
    exp_b.push_back(8'h0A);
    check_bytes("t2");
    finish_ack("t2");

    // LF only, req held: ack stays up and no second print.
    start(2'd2, 2'd3, 32'h0);
    collect(0, 0);
    exp_b = '{8'h0A};
    check_bytes("t3");
    check("t3_ack_rise", ack_cyc, last_cyc + 1);
    for (int i = 0; i < 18; i++) begin
      step();
      check("t3_ack_hold", {31'h0, s_ack}, 32'h1);
      check("t3_no_repeat", {31'h0, s_vld}, 32'h0);
    end
    req[2] = 1'b0;
    step();
    check("t3_ack_fall", {31'h0, s_ack}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_quiet_vld", {31'h0, s_vld}, 32'h0);
      check("t3_quiet_busy", {31'h0, s_busy}, 32'h0);
    end

    // Reset mid-transfer after the 3rd byte.
    start(2'd0, 2'd1, 32'hDEADBEEF);
    collect(0, 3);
    exp_b = '{8'h44, 8'h45, 8'h41};
    check_bytes("t4");
    rst = 1'b1; req[0] = 1'b0;
    step();
    check("t4_rst_vld", {31'h0, vld[0]}, 32'h0);
    check("t4_rst_dat", {24'h0, dat[0]}, 32'h0);
    check("t4_rst_ack", {31'h0, ack[0]}, 32'h0);
    check("t4_rst_busy", {31'h0, busy[0]}, 32'h0);
    rst = 1'b0;
    step();
    start(2'd0, 2'd0, 32'h000000A5);
    collect(0, 0);
    exp_b = '{8'hA5};
    check_bytes("t4_after");
    finish_ack("t4_after");

    // Digits + optional separator + CR LF.
    start(2'd0, 2'd2, 32'h00000001);
    collect(0, 0);
    exp_b = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31};
    if (SEP) exp_b.push_back(8'h20);
    exp_b.push_back(8'h0D);
    exp_b.push_back(8'h0A);
    check_bytes("t5");
    finish_ack("t5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
